ipf_lcu_sched: RTL and testbench

- Front-end scheduler for the image processing filter (IPF) datapath.
- Walks the image in LCU raster order and reads pixels from the image memory (1-cycle read latency). Each LCU is streamed row-major into the filter.
- Fetches per-LCU filter configuration from a parameter memory. Drives in_en/din plus lcu_x, lcu_y and ipf_* so that every LCU is gapless back-to-back.
- Honours the filter's busy, then waits for the filter's finish before reporting done.

---
 rtl/ipf_lcu_sched_if.sv | 52 +++++
 rtl/ipf_lcu_sched.sv | 164 ++++++++++++++++
 tb/tb_ipf_lcu_sched.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/ipf_lcu_sched_if.sv
// Scheduler-side bundle: image/parameter memory ports, filter stream and control.
// stall_cnt is present only when IPF_SCHED_PERF_EN is defined.
interface ipf_lcu_sched_if #(
  parameter int LCU_LOG  = 4,
  parameter int GRID_LOG = 3,
  parameter int PAR_W    = 24
);
  localparam int ADDR_W = 2 * (LCU_LOG + GRID_LOG);

  logic                  start;
  logic [ADDR_W-1:0]     img_addr;
  logic                  img_rd;
  logic [7:0]            img_data;
  logic [2*GRID_LOG-1:0] par_addr;
  logic                  par_rd;
  logic [PAR_W-1:0]      par_data;
  logic                  busy;
  logic                  finish;
  logic                  in_en;
  logic [7:0]            din;
  logic [1:0]            ipf_type;
  logic [4:0]            ipf_band_pos;
  logic                  ipf_wo_class;
  logic [15:0]           ipf_offset;
  logic [GRID_LOG-1:0]   lcu_x;
  logic [GRID_LOG-1:0]   lcu_y;
  logic                  sched_busy;
  logic                  done;
`ifdef IPF_SCHED_PERF_EN
  logic [15:0]           stall_cnt;
`endif

  modport master (
    input  start, img_data, par_data, busy, finish,
`ifdef IPF_SCHED_PERF_EN
    output stall_cnt,
`endif
    output img_addr, img_rd, par_addr, par_rd, in_en, din,
           ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset,
           lcu_x, lcu_y, sched_busy, done
  );

  modport slave (
    output start, img_data, par_data, busy, finish,
`ifdef IPF_SCHED_PERF_EN
    input  stall_cnt,
`endif
    input  img_addr, img_rd, par_addr, par_rd, in_en, din,
           ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset,
           lcu_x, lcu_y, sched_busy, done
  );
endinterface

// File: rtl/ipf_lcu_sched.sv
// IPF front-end scheduler: raster LCU walk, row-major pixel stream, per-LCU params (IPF_SCHED_PERF_EN adds stall_cnt).
// Latency: par_rd on the start cycle, first img_rd +2, first in_en +3; LCUs back-to-back with no bubbles.
// Backpressure: busy parks the in-flight pixel in a 1-entry skid and halts reads until it drains.
module ipf_lcu_sched #(
  parameter int LCU_LOG  = 4,
  parameter int GRID_LOG = 3,
  parameter int PAR_W    = 24
) (
  input logic             clk,
  input logic             reset,
  ipf_lcu_sched_if.master bus
);
  localparam int PIX_W = 2 * LCU_LOG;
  localparam int LCU_W = 2 * GRID_LOG;
  localparam int CNT_W = PIX_W + LCU_W;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [LCU_W-1:0] LCU_ONE = LCU_W'(1);

  typedef struct packed {
    logic [1:0]  typ;
    logic [4:0]  band_pos;
    logic        wo_class;
    logic [15:0] offset;
  } par_t;

  typedef enum logic [2:0] {S_IDLE, S_PARAM, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] iss_cnt;   // {lcu_y, lcu_x, row, col} of the next read
  logic             iss_done;
  logic [CNT_W-1:0] acc_cnt;   // {lcu_y, lcu_x, pixel} of the next pixel to be accepted
  logic             rd_vld;
  logic             skid_vld;
  logic [7:0]       skid_dat;
  logic             par_pend;
  par_t             act_par;
  par_t             shd_par;

  logic [PAR_W-1:0] par_word;
  par_t             par_in;
  logic [LCU_W-1:0] acc_lcu;
  logic [7:0]       din;
  logic             start_acc, in_en, accept, stall, img_rd;
  logic             pix_first, pix_last, lcu_last, prefetch;
  logic             done_c, sched_busy_c;

  assign par_word  = bus.par_data;
  assign par_in    = par_t'(par_word);
  assign acc_lcu   = acc_cnt[CNT_W-1:PIX_W];
  assign start_acc = (state == S_IDLE) && bus.start;

  // Only one of skid/return can hold a word: reads stop the cycle a word is left over.
  assign in_en  = skid_vld | rd_vld;
  assign din    = skid_vld ? skid_dat : (rd_vld ? bus.img_data : 8'h00);
  assign stall  = in_en & bus.busy;
  assign accept = in_en & ~bus.busy;
  assign img_rd = (state == S_STREAM) && !iss_done && !stall;

  assign pix_first = (acc_cnt[PIX_W-1:0] == '0);
  assign pix_last  = &acc_cnt[PIX_W-1:0];
  assign lcu_last  = &acc_lcu;
  assign prefetch  = (state == S_STREAM) && accept && pix_first && !lcu_last;

  always_comb begin
    state_nxt    = state;
    done_c       = 1'b0;
    sched_busy_c = 1'b1;
    case (state)
      S_IDLE: begin
        sched_busy_c = 1'b0;
        if (bus.start) state_nxt = S_PARAM;
      end
      S_PARAM:  state_nxt = S_STREAM;
      S_STREAM: if (accept && pix_last && lcu_last) state_nxt = S_DRAIN;
      S_DRAIN:  if (bus.finish) state_nxt = S_DONE;
      S_DONE: begin
        done_c    = 1'b1;
        state_nxt = S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      iss_cnt  <= '0;
      iss_done <= 1'b0;
    end else if (start_acc) begin
      iss_cnt  <= '0;
      iss_done <= 1'b0;
    end else if (img_rd) begin
      iss_cnt  <= iss_cnt + CNT_ONE;
      iss_done <= &iss_cnt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_vld   <= 1'b0;
      skid_vld <= 1'b0;
      skid_dat <= 8'h00;
    end else begin
      rd_vld   <= img_rd;
      skid_vld <= stall;
      if (stall) skid_dat <= din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         acc_cnt <= '0;
    else if (start_acc) acc_cnt <= '0;
    else if (accept)    acc_cnt <= acc_cnt + CNT_ONE;
  end

  // Active params swap from the shadow only once the LCU's last pixel is taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act_par  <= '0;
      shd_par  <= '0;
      par_pend <= 1'b0;
    end else begin
      par_pend <= prefetch;
      if (par_pend) shd_par <= par_in;
      if (state == S_PARAM)      act_par <= par_in;
      else if (accept && pix_last) act_par <= shd_par;
    end
  end

`ifdef IPF_SCHED_PERF_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_cnt <= 16'h0000;
    else if (start_acc)
      stall_cnt <= 16'h0000;
    else if ((state == S_STREAM) && stall && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'h0001;
  end

  assign bus.stall_cnt = stall_cnt;
`endif

  assign bus.img_addr     = {iss_cnt[CNT_W-1:PIX_W+GRID_LOG], iss_cnt[PIX_W-1:LCU_LOG],
                             iss_cnt[PIX_W+GRID_LOG-1:PIX_W], iss_cnt[LCU_LOG-1:0]};
  assign bus.img_rd       = img_rd;
  assign bus.par_rd       = start_acc | prefetch;
  assign bus.par_addr     = prefetch ? (acc_lcu + LCU_ONE) : '0;
  assign bus.in_en        = in_en;
  assign bus.din          = din;
  assign bus.ipf_type     = act_par.typ;
  assign bus.ipf_band_pos = act_par.band_pos;
  assign bus.ipf_wo_class = act_par.wo_class;
  assign bus.ipf_offset   = act_par.offset;
  assign bus.lcu_x        = acc_lcu[GRID_LOG-1:0];
  assign bus.lcu_y        = acc_lcu[LCU_W-1:GRID_LOG];
  assign bus.sched_busy   = sched_busy_c;
  assign bus.done         = done_c;
endmodule

// File: tb/tb_ipf_lcu_sched.sv
// Bench for ipf_lcu_sched: memory models, random busy, and a frame-level pixel/parameter reference.
module tb_ipf_lcu_sched;
  localparam int LCU_LOG  = 4;
  localparam int GRID_LOG = 3;
  localparam int PAR_W    = 24;
  localparam int LCU      = 1 << LCU_LOG;
  localparam int GRID     = 1 << GRID_LOG;
  localparam int LCU_PIX  = LCU * LCU;
  localparam int NLCU     = GRID * GRID;
  localparam int FRAME    = LCU_PIX * NLCU;

  logic clk = 1'b0;
  logic reset;

  ipf_lcu_sched_if #(.LCU_LOG(LCU_LOG), .GRID_LOG(GRID_LOG), .PAR_W(PAR_W)) bus ();

  ipf_lcu_sched #(.LCU_LOG(LCU_LOG), .GRID_LOG(GRID_LOG), .PAR_W(PAR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]       img_mem [FRAME];
  logic [PAR_W-1:0] par_mem [NLCU];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int exp_n    = 0;
  int stall_m  = 0;
  int done_cnt = 0;
  int start_cyc = 0, first_rd_cyc = -1, first_en_cyc = -1, finish_cyc = -100, done_cyc = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference for pixel n of the frame: LCU raster, row-major inside the LCU.
  function automatic logic [63:0] exp_vec(input int n);
    int k, p, lx, ly, r, c, a;
    logic [PAR_W-1:0] w;
    k  = n / LCU_PIX;
    p  = n % LCU_PIX;
    ly = k / GRID;
    lx = k % GRID;
    r  = p / LCU;
    c  = p % LCU;
    a  = ((ly * LCU + r) * GRID + lx) * LCU + c;
    w  = par_mem[k];
    return {26'd0, img_mem[a], w[23:22], w[21:17], w[16], w[15:0], 3'(ly), 3'(lx)};
  endfunction

  function automatic logic [63:0] obs_vec();
    return {26'd0, bus.din, bus.ipf_type, bus.ipf_band_pos, bus.ipf_wo_class,
            bus.ipf_offset, bus.lcu_y, bus.lcu_x};
  endfunction

  function automatic logic [63:0] outs_now();
    return {1'b0, bus.img_addr, bus.img_rd, bus.par_addr, bus.par_rd, bus.in_en, bus.din,
            bus.ipf_type, bus.ipf_band_pos, bus.ipf_wo_class, bus.ipf_offset,
            bus.lcu_x, bus.lcu_y, bus.sched_busy, bus.done};
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.img_rd) bus.img_data <= img_mem[bus.img_addr];
    if (bus.par_rd) bus.par_data <= par_mem[bus.par_addr];
  end

  always @(negedge clk) begin
    if (!reset) begin
      exp_n = 0;
    end else begin
      if (bus.start && !bus.sched_busy) begin
        exp_n        = 0;
        stall_m      = 0;
        start_cyc    = cyc;
        first_rd_cyc = -1;
        first_en_cyc = -1;
        finish_cyc   = -100;
        check_eq("par_rd_on_start", {bus.par_rd, bus.par_addr}, {1'b1, 6'd0});
      end
      if (bus.img_rd && first_rd_cyc < 0) first_rd_cyc = cyc;
      if (bus.in_en) begin
        if (first_en_cyc < 0) first_en_cyc = cyc;
        if (exp_n < FRAME) check_eq("pix", obs_vec(), exp_vec(exp_n));
        else               check_eq("extra_pix", exp_n, FRAME - 1);
        if (bus.busy) stall_m++;
        else          exp_n++;
      end
      if (bus.finish && exp_n == FRAME) finish_cyc = cyc;
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
        check_eq("done_after_frame", exp_n, FRAME);
      end
    end
  end

  task automatic fill(input bit basic);
    for (int a = 0; a < FRAME; a++) img_mem[a] = basic ? 8'(a) : 8'($urandom);
    for (int n = 0; n < NLCU; n++)
      par_mem[n] = basic ? {2'd1, 5'(n), 1'b0, 16'h1234} : PAR_W'($urandom);
  endtask

  task automatic run_frame(input int stall_pix, input int stall_len, input int rnd_pct,
                           input bit inject, input int abort_at, input int exp_stall);
    int  dn, g, hold, stop;
    bit  fired;
    dn    = done_cnt;
    hold  = 0;
    fired = 1'b0;
    stop  = (abort_at > 0) ? abort_at : FRAME;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.busy  = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check_eq("sched_busy_on", bus.sched_busy, 1);
    g = 0;
    while (exp_n < stop && g < 60000) begin
      bus.busy   = 1'b0;
      bus.start  = 1'b0;
      bus.finish = 1'b0;
      if (hold > 0) begin
        bus.busy = 1'b1;
        hold--;
      end else if (!fired && bus.in_en && exp_n == stall_pix) begin
        bus.busy = 1'b1;
        fired    = 1'b1;
        hold     = stall_len - 1;
      end else if (rnd_pct > 0 && int'($urandom_range(99)) < rnd_pct) begin
        bus.busy = 1'b1;
      end
      if (inject && exp_n == 3000) bus.start  = 1'b1;
      if (inject && exp_n == 5000) bus.finish = 1'b1;
      @(posedge clk); #1;
      g++;
    end
    bus.busy   = 1'b0;
    bus.start  = 1'b0;
    bus.finish = 1'b0;
    check_eq("stream_reach", exp_n >= stop, 1);

    if (abort_at > 0) begin
      reset = 1'b0;
      #1;
      check_eq("rst_mid_outs", outs_now(), 0);
      @(posedge clk); #1;
      check_eq("rst_mid_hold", outs_now(), 0);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("abort_no_done", done_cnt, dn);
      check_eq("abort_idle", bus.sched_busy, 0);
      return;
    end

    repeat (4) begin
      @(posedge clk); #1;
      check_eq("drain_quiet", {bus.in_en, bus.img_rd, bus.done}, 0);
    end
    check_eq("no_done_before_finish", done_cnt, dn);
    bus.finish = 1'b1;
    @(posedge clk); #1;
    bus.finish = 1'b0;
    g = 0;
    while (done_cnt == dn && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    check_eq("done_cnt", done_cnt, dn + 1);
    check_eq("done_lat", done_cyc - finish_cyc, 1);
    check_eq("pix_count", exp_n, FRAME);
    check_eq("first_rd_lat", first_rd_cyc - start_cyc, 2);
    check_eq("first_en_lat", first_en_cyc - start_cyc, 3);
    check_eq("idle_after_done", bus.sched_busy, 0);
    if (exp_stall >= 0) check_eq("stall_cycles", stall_m, exp_stall);
`ifdef IPF_SCHED_PERF_EN
    check_eq("stall_cnt", bus.stall_cnt, stall_m);
    if (exp_stall >= 0) check_eq("stall_cnt_fixed", bus.stall_cnt, exp_stall);
`endif
  endtask

  initial begin
    reset      = 1'b0;
    bus.start  = 1'b0;
    bus.busy   = 1'b0;
    bus.finish = 1'b0;
    fill(1'b1);
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outs", outs_now(), 0);
`ifdef IPF_SCHED_PERF_EN
    check_eq("reset_stall_cnt", bus.stall_cnt, 0);
`endif
    reset = 1'b1;
    @(posedge clk); #1;

    // Basic frame with a 5-cycle stall on pixel 5.
    run_frame(5, 5, 0, 1'b0, 0, 5);
    // Random data/params, stall on LCU 0 last pixel, random busy, stray start/finish.
    fill(1'b0);
    run_frame(LCU_PIX - 1, 3, 20, 1'b1, 0, -1);
    // Reset at pixel 1000, then a full frame from scratch.
    fill(1'b0);
    run_frame(-1, 0, 10, 1'b0, 1000, -1);
    run_frame(-1, 0, 10, 1'b0, 0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
